// File: rtl/arm_pkg.sv
// Shared ARM field positions and the NZCV flag type used by the fetch/issue
// slice of the core.
package arm_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int CLASS_HI = 27;
  localparam int CLASS_LO = 26;
  localparam int S_BIT    = 20;

  localparam logic [1:0] CLASS_DP = 2'b00;

  typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/ir_flag_stage_if.sv
// Fetch-side and issue-side handshakes of the instruction/flag stage.
// Valid/ready: a word moves on a rising edge where valid & ready are both high;
// valid never depends combinationally on ready, and ready may rise or fall freely.
interface ir_flag_stage_if #(parameter int IW = 32);
  logic [IW-1:0] mem_data;
  logic          mem_valid;
  logic          mem_ready;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] ir_out;
  logic [3:0]    cond;

  modport master (
    output mem_data, mem_valid, out_ready,
    input  mem_ready, out_valid, ir_out, cond
  );

  modport slave (
    input  mem_data, mem_valid, out_ready,
    output mem_ready, out_valid, ir_out, cond
  );
endinterface

// File: rtl/instr_fifo.sv
// Small instruction buffer with flush; head holds the last popped word while
// empty so downstream sees a stable value.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic [W-1:0]  last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        last_q <= mem[rptr];
        rptr   <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign count = cnt;
  assign head  = empty ? last_q : mem[rptr];

endmodule

// File: rtl/ir_flag_stage.sv
// Buffers fetched words, holds NZCV, and withholds issue while an issued
// flag-setting instruction has not yet written its flags back.
module ir_flag_stage
  import arm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IW    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  ir_flag_stage_if.slave     bus,
  input  logic               flush,
  input  nzcv_t              alu_flags,
  input  logic               flags_we,
  input  logic               cond_pass,
  output nzcv_t              flags,
  output logic               flag_pending
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [IW-1:0] head;
  logic          sets_flags;
  nzcv_t         flags_q;
  logic          pending_q;

  // Flush drops any word offered in the same cycle.
  assign push = bus.mem_valid & bus.mem_ready & ~flush;
  assign pop  = bus.out_valid & bus.out_ready;

  instr_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (bus.mem_data),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.mem_ready = (count < CW'(DEPTH));
  assign bus.out_valid = ~empty & ~pending_q & ~flush;
  assign bus.ir_out    = head;
  assign bus.cond      = head[COND_HI:COND_LO];

  assign sets_flags = (head[CLASS_HI:CLASS_LO] == CLASS_DP) & head[S_BIT];

  // A new writer issuing in the same cycle as a completing write keeps pending high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      flags_q   <= '0;
    end else begin
      if (pop & sets_flags & cond_pass) pending_q <= 1'b1;
      else if (flags_we)                pending_q <= 1'b0;
      if (flags_we) flags_q <= alu_flags;
    end
  end

  assign flags        = flags_q;
  assign flag_pending = pending_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule
